// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, flag-index and FSM definitions for the ALU control sequencer.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_NEGA = 5'b00000;
    localparam logic [4:0] OP_INCA = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_ADDC = 5'b00011;
    localparam logic [4:0] OP_DECA = 5'b00100;
    localparam logic [4:0] OP_SUBB = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_PASA = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOTA = 5'b01011;
    localparam logic [4:0] OP_NAND = 5'b01100;
    localparam logic [4:0] OP_NOR  = 5'b01101;
    localparam logic [4:0] OP_XNOR = 5'b01110;
    localparam logic [4:0] OP_SHL  = 5'b01111;
    localparam logic [4:0] OP_SHR  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10000;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic op_illegal(input logic [4:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_controller_regfile.sv
// General register file: one synchronous write port, three combinational read ports.
module alu_regfile #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    input  logic [AW-1:0]    ra_d,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] rdata_d
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[ra_a];
        rdata_b = regs[ra_b];
        rdata_d = regs[ra_d];
    end

endmodule

// File: rtl/alu_controller.sv
// Multi-cycle sequencer: fetch operands, drive the external ALU, capture and commit.
module alu_controller
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4:0]       instr_op,
    input  logic [AW-1:0]    instr_da,
    input  logic [AW-1:0]    instr_sa,
    input  logic [AW-1:0]    instr_sb,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_fsec,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] alu_fout,
    input  logic [3:0]       alu_signal,
    output logic [3:0]       status,
    output logic             done,
    output logic             err
);

    state_t           state, state_nxt;
    logic [AW-1:0]    da_q;
    logic             illegal_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_q;

    logic             accept;
    logic             commit;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] opnd_a, opnd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                commit    = !illegal_q;
                done      = !illegal_q;
                err       = illegal_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Commit and load share the write port; they are exclusive by state, and
    // operands are read combinationally so a same-edge load is read-before-write.
    always_comb begin
        rf_we    = commit || (instr_ready && ld_en);
        rf_waddr = commit ? da_q  : ld_addr;
        rf_wdata = commit ? res_q : ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fsec  <= '0;
            alu_carry <= 1'b0;
            da_q      <= '0;
            illegal_q <= 1'b0;
            res_q     <= '0;
            flg_q     <= '0;
            status    <= '0;
        end else begin
            if (accept) begin
                alu_a     <= opnd_a;
                alu_b     <= opnd_b;
                alu_fsec  <= instr_op;
                alu_carry <= status[FLG_C];
                da_q      <= instr_da;
                illegal_q <= op_illegal(instr_op);
            end
            if (state == ST_EXEC) begin
                res_q <= alu_fout;
                flg_q <= alu_signal;
            end
            if (commit) status <= flg_q;
        end
    end

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .ra_a    (instr_sa),
        .ra_b    (instr_sb),
        .ra_d    (rd_addr),
        .rdata_a (opnd_a),
        .rdata_b (opnd_b),
        .rdata_d (rd_data)
    );

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller with a stand-in ALU and an issue/complete scoreboard.
module tb_alu_controller;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_da, instr_sa, instr_sb;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [63:0] ld_data;
    logic [2:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] alu_a, alu_b;
    logic [4:0]  alu_fsec;
    logic        alu_carry;
    logic [63:0] alu_fout;
    logic [3:0]  alu_signal;
    logic [3:0]  status;
    logic        done, err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        carry;
        logic        illegal;
        int unsigned acc_cyc;
    } exp_t;

    exp_t sb_q[$];

    alu_controller #(
        .WIDTH (64),
        .NREGS (8),
        .AW    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_da    (instr_da),
        .instr_sa    (instr_sa),
        .instr_sb    (instr_sb),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fsec    (alu_fsec),
        .alu_carry   (alu_carry),
        .alu_fout    (alu_fout),
        .alu_signal  (alu_signal),
        .status      (status),
        .done        (done),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: add, add-with-carry, subtract; anything else returns a^b with flags 1100.
    always_comb begin
        logic [64:0] wide;
        logic        cy, ov;
        wide = '0;
        cy   = 1'b0;
        ov   = 1'b0;
        case (alu_fsec)
            5'b00010: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                cy   = wide[64];
                ov   = (alu_a[63] == alu_b[63]) && (wide[63] != alu_a[63]);
            end
            5'b00011: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_carry};
                cy   = wide[64];
                ov   = (alu_a[63] == alu_b[63]) && (wide[63] != alu_a[63]);
            end
            5'b00110: begin
                wide = {1'b0, alu_a} - {1'b0, alu_b};
                cy   = ~wide[64];
                ov   = (alu_a[63] != alu_b[63]) && (wide[63] != alu_a[63]);
            end
            default: begin
                wide = {1'b0, alu_a ^ alu_b};
                cy   = 1'b1;
                ov   = 1'b1;
            end
        endcase
        alu_fout   = wide[63:0];
        alu_signal = {ov, cy, wide[63], wide[63:0] == 64'd0};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Completion monitor: every done/err pulse must match the oldest issued instruction.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            check("pulse_has_issue", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_kind",   64'(done),      64'(!e.illegal));
                check("err_kind",    64'(err),       64'(e.illegal));
                check("pulse_cycle", 64'(cyc),       64'(e.acc_cyc + 1));
                check("alu_fsec",    64'(alu_fsec),  64'(e.op));
                check("alu_a",       alu_a,          e.a);
                check("alu_b",       alu_b,          e.b);
                check("alu_carry",   64'(alu_carry), 64'(e.carry));
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [63:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic c);
        exp_t e;
        e = '{op, a, b, c, (op > 5'b10000), cyc + 1};
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] da, input logic [63:0] exp_a, input logic [63:0] exp_b,
                         input logic exp_c, input logic [63:0] exp_rd, input logic [3:0] exp_st);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_sa    = sa;
        instr_sb    = sb;
        instr_da    = da;
        push_exp(op, exp_a, exp_b, exp_c);
        check("ready_idle", 64'(instr_ready), 64'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        check("ready_exec", 64'(instr_ready), 64'd0);
        check("quiet_exec", 64'({done, err}), 64'd0);
        @(negedge clk);
        check("ready_wb", 64'(instr_ready), 64'd0);
        @(negedge clk);
        check("ready_back", 64'(instr_ready), 64'd1);
        check("status", 64'(status), 64'(exp_st));
        rd_addr = da;
        #1;
        check("rd_dest", rd_data, exp_rd);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_da    = '0;
        instr_sa    = '0;
        instr_sb    = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        rd_addr     = '0;

        repeat (2) @(negedge clk);
        check("rst_ready",  64'(instr_ready), 64'd1);
        check("rst_status", 64'(status), 64'd0);
        check("rst_pulses", 64'({done, err}), 64'd0);
        check("rst_alu_a",  alu_a, 64'd0);
        rst_n = 1'b1;

        // Add
        load(3'd1, 64'd5);
        load(3'd2, 64'd3);
        issue(5'b00010, 3'd1, 3'd2, 3'd3, 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000);

        // Carry chain: wrap to zero, then carry-in feeds add-with-carry
        load(3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        load(3'd2, 64'd1);
        issue(5'b00010, 3'd1, 3'd2, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101);
        load(3'd4, 64'd0);
        load(3'd5, 64'd0);
        issue(5'b00011, 3'd4, 3'd5, 3'd6, 64'd0, 64'd0, 1'b1, 64'd1, 4'b0000);

        // Subtract to a negative result
        load(3'd1, 64'd3);
        load(3'd2, 64'd5);
        issue(5'b00110, 3'd1, 3'd2, 3'd7, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);

        // Illegal opcode: err pulse, destination and status untouched
        load(3'd3, 64'hDEAD);
        issue(5'b10101, 3'd1, 3'd2, 3'd3, 64'd3, 64'd5, 1'b0, 64'hDEAD, 4'b0010);

        // Back-to-back with instr_valid held; load during EXEC is ignored
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 5'b00010;
        instr_sa    = 3'd1;
        instr_sb    = 3'd2;
        instr_da    = 3'd4;
        push_exp(5'b00010, 64'd3, 64'd5, 1'b0);
        @(negedge clk);
        instr_sa = 3'd4;
        instr_sb = 3'd4;
        instr_da = 3'd5;
        ld_en    = 1'b1;
        ld_addr  = 3'd1;
        ld_data  = 64'd99;
        check("b2b_ready_exec", 64'(instr_ready), 64'd0);
        @(negedge clk);
        ld_en = 1'b0;
        check("b2b_ready_wb", 64'(instr_ready), 64'd0);
        @(negedge clk);
        check("b2b_ready_idle", 64'(instr_ready), 64'd1);
        push_exp(5'b00010, 64'd8, 64'd8, 1'b0);
        @(negedge clk);
        instr_valid = 1'b0;
        check("b2b2_ready_exec", 64'(instr_ready), 64'd0);
        repeat (2) @(negedge clk);
        rd_addr = 3'd5;
        #1;
        check("b2b_r5", rd_data, 64'd16);
        rd_addr = 3'd1;
        #1;
        check("ld_exec_ignored", rd_data, 64'd3);

        // Load to sa on the accept edge: old value used, new value stored
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 5'b00010;
        instr_sa    = 3'd1;
        instr_sb    = 3'd2;
        instr_da    = 3'd6;
        ld_en       = 1'b1;
        ld_addr     = 3'd1;
        ld_data     = 64'd100;
        push_exp(5'b00010, 64'd3, 64'd5, 1'b0);
        @(negedge clk);
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        repeat (2) @(negedge clk);
        rd_addr = 3'd6;
        #1;
        check("rbw_r6", rd_data, 64'd8);
        rd_addr = 3'd1;
        #1;
        check("rbw_r1", rd_data, 64'd100);

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 5'b00010;
        instr_sa    = 3'd1;
        instr_sb    = 3'd2;
        instr_da    = 3'd3;
        @(negedge clk);
        instr_valid = 1'b0;
        check("abort_alu_a_pre", alu_a, 64'd100);
        rst_n = 1'b0;
        #1;
        check("abort_pulses", 64'({done, err}), 64'd0);
        check("abort_alu_a",  alu_a, 64'd0);
        check("abort_alu_b",  alu_b, 64'd0);
        check("abort_fsec",   64'(alu_fsec), 64'd0);
        check("abort_carry",  64'(alu_carry), 64'd0);
        check("abort_ready",  64'(instr_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_ready", 64'(instr_ready), 64'd1);
        check("post_rst_status", 64'(status), 64'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check("post_rst_rf", rd_data, 64'd0);
        end
        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_controller.md
Name: alu_controller

Overview:
- Multi-cycle control sequencer that drives the 64-bit ALU from the initiator side.
- Accepts a three-address instruction (opcode, dest, srcA, srcB) over a valid/ready handshake and reads both operands from an internal register file.
- Drives the ALU's A/B/fsec/carry inputs, then captures fout and the 4-bit signal flags.
- Writes the result back to the register file and the flags into a status register. The ALU block itself is external and purely combinational.

Parameters:
- WIDTH, 64, datapath width; must match the ALU operand width.
- NREGS, 8, number of general registers.
- AW, 3, register address width; must equal clog2(NREGS).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept an instruction.
- instr_op  input  5  ALU opcode (fsec encoding).
- instr_da  input  AW  destination register.
- instr_sa  input  AW  source A register.
- instr_sb  input  AW  source B register.
- ld_en  input  1  external register load strobe.
- ld_addr  input  AW  load address.
- ld_data  input  WIDTH  load data.
- rd_addr  input  AW  debug read address.
- rd_data  output  WIDTH  combinational read of rf[rd_addr].
- alu_a  output  WIDTH  ALU operand A (registered).
- alu_b  output  WIDTH  ALU operand B (registered).
- alu_fsec  output  5  ALU opcode (registered).
- alu_carry  output  1  ALU carry in (registered).
- alu_fout  input  WIDTH  ALU result.
- alu_signal  input  4  ALU flags: [0] zero, [1] negative, [2] unsigned carry, [3] signed overflow.
- status  output  4  last committed flags.
- done  output  1  one-cycle pulse: legal op committed.
- err  output  1  one-cycle pulse: illegal opcode.

Behaviour:
- Reset: asynchronous on rst_n low, released on rst_n high.
  - FSM goes to IDLE.
  - All rf entries, status, alu_a, alu_b, alu_fsec, alu_carry, done and err clear to 0.
  - instr_ready = 1 while in reset.
  - Reset asserted mid-operation aborts the instruction with no writeback.
- FSM has three states: IDLE -> EXEC -> WB -> IDLE.
  - instr_ready = 1 only in IDLE.
  - Accept occurs on an edge where instr_valid and instr_ready are both high.
- Accept edge (IDLE -> EXEC):
  - alu_a <= rf[sa], alu_b <= rf[sb].
  - alu_fsec <= op, alu_carry <= status[2].
  - Latch da and an illegal flag (op > 5'b10000).
- EXEC: the ALU settles. At the end-of-EXEC edge, res_q <= alu_fout and flg_q <= alu_signal; go to WB.
- WB, legal op:
  - done = 1 for this cycle.
  - At the end-of-WB edge, rf[da] <= res_q and status <= flg_q; go to IDLE.
- WB, illegal op:
  - err = 1, done = 0.
  - No rf or status update.
- Timing: done/err is high exactly 2 cycles after the accept edge. Throughput is one instruction per 3 cycles. instr_valid held high is re-accepted on the first IDLE cycle.
- alu_* outputs hold their values until the next accept.
- Load port:
  - ld_en is honoured only in IDLE; rf[ld_addr] <= ld_data. It is silently ignored in EXEC and WB.
  - Load and accept on the same edge: operands are read pre-load (read-before-write).
  - This also applies when ld_addr equals sa or sb.
- Aliasing: da may equal sa/sb. The write occurs at the end of WB, so operands are already captured and aliasing is safe.
- Width rules: all arithmetic is done by the ALU; the controller never modifies data. Flags are stored verbatim.
- rd_data is a combinational read. It reflects a WB commit the cycle after the commit edge.

Decomposition:
- Package alu_ctrl_pkg:
  - Opcode constants OP_NEGA (00000) through OP_SHR (10000) and OP_MAX = 5'b10000.
  - Flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
  - FSM state enum.
- Sub-module alu_regfile:
  - NREGS x WIDTH registers, async clear.
  - One sync write port, muxed between WB commit and load.
  - Three combinational read ports: sa, sb, rd.

Test Plan:
1. Add: load R1=5, R2=3; accept op 00010, sa=1, sb=2, da=3 -> done high at accept+2, then R3=8, status=4'b0000, instr_ready low for 2 cycles.
2. Carry chain: R1=64'hFFFF_FFFF_FFFF_FFFF, R2=1, op 00010 -> R3=0, status=4'b0101. Then R4=R5=0, op 00011, da=6 -> alu_carry=1 and R6=1.
3. Subtract: R1=3, R2=5, op 00110, da=7 -> R7=64'hFFFF_FFFF_FFFF_FFFE, status[1]=1.
4. Illegal op 5'b10101 -> err pulse at accept+2, done=0, destination register and status unchanged, back in IDLE at accept+3.
5. Back-to-back: instr_valid held high for two instructions -> accepts at T and T+3. ld_en pulsed during EXEC is ignored. ld_en with ld_addr=sa on the accept edge -> the old value is used for that instruction and the new value is stored.
6. Reset: rst_n low during EXEC -> done, err and alu_* go to 0 immediately. After release: instr_ready=1, rd_data=0 for all addresses, no late done pulse.
